button_arbiter: RTL and testbench
=================================

# button_arbiter

Arbitrates one-cycle button pulses from several debounced/one-pulsed push-button chains and presents one winner at a time to the game-control FSM. It grants the first press in a round and resolves same-cycle presses with a rotating round-robin priority. The winner is held until the FSM acknowledges it, after which a lockout window blocks further presses. The block sits between the per-button debounce/pulse stages and the game FSM, in the single system clock domain.

## Interface
- `ID_W`, default 2: requester index width; number of requesters `N_REQ = 2**ID_W`.
- `LOCK_W`, default 16: lockout counter width.
- `LOCK_CYCLES`, default 1000: lockout length in clk cycles; must be below `2**LOCK_W`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  arms arbitration; set by the game FSM while a question is open.
- `req`  in  N_REQ  one-cycle press pulses; bit i is requester i.
- `grant_ack`  in  1  FSM has consumed the current grant.
- `grant_valid`  out  1  a winner is being presented.
- `grant_id`  out  ID_W  winner index; meaningful only while `grant_valid`=1.
- `grant_onehot`  out  N_REQ  one-hot winner; all zero when `grant_valid`=0.
- `dropped`  out  1  one-cycle pulse; at least one press was lost on the previous cycle.
- `busy`  out  1  high in GRANT or LOCKOUT.

## Operation
- States are IDLE, GRANT and LOCKOUT. Reset forces IDLE, `rr_ptr`=0, lock counter=0, and drives all outputs to 0.
- **IDLE**:
  - If `enable`=1 and `req`≠0, pick the first set bit scanning upward from `rr_ptr` with wrap-around.
  - Register that index into `grant_id`/`grant_onehot` and go to GRANT.
  - Any other set `req` bits in the same cycle count as losers and are dropped.
  - If `enable`=0, `req` is ignored and no drop is reported.
- **GRANT**:
  - `grant_valid`=1; `grant_id` and `grant_onehot` stay stable.
  - Every `req` bit seen here is dropped.
  - On `grant_ack`=1: set `rr_ptr` to (`grant_id`+1) mod `N_REQ`, clear the grant, and go to LOCKOUT, loading the counter with `LOCK_CYCLES`.
  - If `LOCK_CYCLES`=0 or the lockout feature is compiled out, go to IDLE instead.
- **LOCKOUT**:
  - The counter decrements once per cycle. When the counter reads 1, the next state is IDLE.
  - Every `req` bit seen here is dropped.
- **Abort**: `enable`=0 in GRANT or LOCKOUT sends the block to IDLE on the next cycle. The grant clears, `rr_ptr` is unchanged, and the counter clears. Abort has priority over `grant_ack`.
- `grant_ack` is ignored outside GRANT.
- `dropped` is asserted the cycle after any dropped press, whether the press lost a same-cycle tie or arrived during GRANT or LOCKOUT with `enable`=1.
- `busy` = (state ≠ IDLE).

## Timing
- All outputs are registered.
- **Request to grant**: `req` at edge t gives `grant_valid`=1 after edge t+1. Latency is 1 cycle.
- **Ack to release**: `grant_ack` at edge t gives `grant_valid`=0 after edge t+1. `grant_ack` may be held high for multiple cycles; only the first cycle in GRANT acts.
- **Lockout length**: LOCKOUT spans exactly `LOCK_CYCLES` cycles. The first `req` accepted after an ack arrives at cycle t+1+`LOCK_CYCLES`, where t is the ack cycle.
- **Re-grant spacing**: a `req` in the first IDLE cycle wins. There is no dead cycle between LOCKOUT and IDLE.
- **Reset mid-operation**: the next cycle is IDLE with all outputs 0 and `rr_ptr`=0. Any pending grant is discarded with no `dropped` pulse.

## Configuration
- `BTN_ARB_LOCKOUT_EN` defined:
  - The LOCKOUT state and lock counter are present.
  - The block behaves as described above.
- Not defined:
  - LOCKOUT and the counter are removed; `LOCK_CYCLES` and `LOCK_W` are unused.
  - An ack returns the block directly to IDLE.
  - `busy` = (state == GRANT).
  - Every other behaviour is unchanged.

## Test plan
All scenarios use `ID_W`=2 and `LOCK_CYCLES`=4.
- **Reset state**: apply `rst` for 2 cycles with `req`=4'b1111. Expect all outputs 0. After release with `enable`=0 and `req` pulsing, expect `grant_valid`=0 and `dropped`=0.
- **Single press**: `enable`=1, `req`=4'b0100 at cycle 10. Expect `grant_valid`=1, `grant_id`=2 and `grant_onehot`=4'b0100 from cycle 11 until the ack.
- **Tie and rotation**: `req`=4'b1010 with `rr_ptr`=0. Expect `grant_id`=1 and `dropped`=1 for one cycle. Ack, wait out the lockout, then `req`=4'b1010 again. Expect `grant_id`=3.
- **Lockout**: ack at cycle 20, with `req`=4'b0001 at cycles 22 and 25. Expect no grant and `dropped`=1 at cycle 23. Expect `grant_valid`=1 at cycle 26.
- **Abort**: in GRANT, drop `enable` at the same cycle as `grant_ack`. Expect `grant_valid`=0 next cycle, `busy`=0, and `rr_ptr` unchanged (verified by the next tie).
- **Macro off**: with `BTN_ARB_LOCKOUT_EN` undefined, ack at cycle 20 and `req`=4'b0001 at cycle 21. Expect `grant_valid`=1 at cycle 22.

Source files
------------

// File: rtl/button_arbiter_if.sv
// Handshake bundle between the button pulse stages / game FSM and button_arbiter.
// master = game-side driver of presses and acks, slave = the arbiter.
interface button_arbiter_if #(
   parameter int ID_W = 2
);
   localparam int N_REQ = 2**ID_W;

   logic             enable;
   logic [N_REQ-1:0] req;
   logic             grant_ack;
   logic             grant_valid;
   logic [ID_W-1:0]  grant_id;
   logic [N_REQ-1:0] grant_onehot;
   logic             dropped;
   logic             busy;

   modport master (
      output enable, req, grant_ack,
      input  grant_valid, grant_id, grant_onehot, dropped, busy
   );

   modport slave (
      input  enable, req, grant_ack,
      output grant_valid, grant_id, grant_onehot, dropped, busy
   );
endinterface

// File: rtl/button_arbiter.sv
// Round-robin arbiter for one-cycle button pulses: grant held until ack, then optional lockout.
// Define BTN_ARB_LOCKOUT_EN to build the LOCKOUT state and its down-counter.
module button_arbiter #(
   parameter int ID_W        = 2,
   parameter int LOCK_W      = 16,
   parameter int LOCK_CYCLES = 1000
) (
   input logic             clk,
   input logic             rst,
   button_arbiter_if.slave bus
);
   localparam int N_REQ = 2**ID_W;
`ifdef BTN_ARB_LOCKOUT_EN
   localparam bit LOCK_BUILD = 1'b1;
`else
   localparam bit LOCK_BUILD = 1'b0;
`endif
   // A zero-length lockout degenerates to returning straight to IDLE.
   localparam bit LOCKOUT_ON = LOCK_BUILD && (LOCK_CYCLES != 0) && (LOCK_W > 0);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      LOCKOUT = 2'd2
   } state_t;

   state_t           state_reg;
   logic [ID_W-1:0]  rr_ptr_reg;
   logic             grant_valid_reg;
   logic [ID_W-1:0]  grant_id_reg;
   logic [N_REQ-1:0] grant_onehot_reg;
   logic             dropped_reg;
   logic             busy_reg;
`ifdef BTN_ARB_LOCKOUT_EN
   logic [LOCK_W-1:0] lock_cnt_reg;
`endif

   logic [ID_W-1:0]  pick_id;
   logic [N_REQ-1:0] pick_onehot;
   logic             req_any;
   logic             req_multi;

   assign req_any   = |bus.req;
   // More than one bit set means at least one same-cycle loser.
   assign req_multi = |(bus.req & (bus.req - N_REQ'(1)));

   always_comb begin
      logic            found;
      logic [ID_W-1:0] idx;
      found   = 1'b0;
      pick_id = '0;
      idx     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = rr_ptr_reg + ID_W'(k);
         if (!found && bus.req[idx]) begin
            found   = 1'b1;
            pick_id = idx;
         end
      end
   end

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_id == ID_W'(gi));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         rr_ptr_reg       <= '0;
         grant_valid_reg  <= 1'b0;
         grant_id_reg     <= '0;
         grant_onehot_reg <= '0;
         dropped_reg      <= 1'b0;
         busy_reg         <= 1'b0;
`ifdef BTN_ARB_LOCKOUT_EN
         lock_cnt_reg     <= '0;
`endif
      end else begin
         dropped_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.enable && req_any) begin
                  state_reg        <= GRANT;
                  grant_valid_reg  <= 1'b1;
                  grant_id_reg     <= pick_id;
                  grant_onehot_reg <= pick_onehot;
                  busy_reg         <= 1'b1;
                  dropped_reg      <= req_multi;
               end
            end
            GRANT: begin
               // Abort wins over a same-cycle ack and leaves rr_ptr alone.
               if (!bus.enable) begin
                  state_reg        <= IDLE;
                  grant_valid_reg  <= 1'b0;
                  grant_onehot_reg <= '0;
                  busy_reg         <= 1'b0;
               end else begin
                  dropped_reg <= req_any;
                  if (bus.grant_ack) begin
                     rr_ptr_reg       <= grant_id_reg + ID_W'(1);
                     grant_valid_reg  <= 1'b0;
                     grant_onehot_reg <= '0;
                     if (LOCKOUT_ON) begin
                        state_reg <= LOCKOUT;
`ifdef BTN_ARB_LOCKOUT_EN
                        lock_cnt_reg <= LOCK_W'(LOCK_CYCLES);
`endif
                     end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                     end
                  end
               end
            end
            LOCKOUT: begin
`ifdef BTN_ARB_LOCKOUT_EN
               if (!bus.enable) begin
                  state_reg    <= IDLE;
                  busy_reg     <= 1'b0;
                  lock_cnt_reg <= '0;
               end else begin
                  dropped_reg <= req_any;
                  // Leaving on count 1 makes the lockout exactly LOCK_CYCLES long.
                  if (lock_cnt_reg <= LOCK_W'(1)) begin
                     state_reg    <= IDLE;
                     busy_reg     <= 1'b0;
                     lock_cnt_reg <= '0;
                  end else begin
                     lock_cnt_reg <= lock_cnt_reg - LOCK_W'(1);
                  end
               end
`else
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
`endif
            end
            default: begin
               state_reg        <= IDLE;
               grant_valid_reg  <= 1'b0;
               grant_onehot_reg <= '0;
               busy_reg         <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant_valid  = grant_valid_reg;
   assign bus.grant_id     = grant_id_reg;
   assign bus.grant_onehot = grant_onehot_reg;
   assign bus.dropped      = dropped_reg;
   assign bus.busy         = busy_reg;
endmodule

// File: tb/tb_button_arbiter.sv
// Scoreboard bench for button_arbiter: stimulus pushes expected grant/drop events, a negedge monitor pops them.
// Builds with or without BTN_ARB_LOCKOUT_EN; the lockout scenarios adapt to the build.
`timescale 1ns/1ps
module tb_button_arbiter;
   localparam int ID_W        = 2;
   localparam int N_REQ       = 4;
   localparam int LOCK_CYCLES = 4;
`ifdef BTN_ARB_LOCKOUT_EN
   localparam logic LOCK_ON = 1'b1;
`else
   localparam logic LOCK_ON = 1'b0;
`endif

   typedef struct {
      bit               is_grant;
      logic [ID_W-1:0]  id;
      logic [N_REQ-1:0] onehot;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   button_arbiter_if #(.ID_W(ID_W)) bus ();

   button_arbiter #(
      .ID_W(ID_W),
      .LOCK_W(16),
      .LOCK_CYCLES(LOCK_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_grant(input logic [ID_W-1:0] id);
      exp_t e;
      e.is_grant = 1'b1;
      e.id       = id;
      e.onehot   = 4'b0001 << id;
      exp_q.push_back(e);
   endtask

   task automatic push_drop();
      exp_t e;
      e.is_grant = 1'b0;
      e.id       = '0;
      e.onehot   = '0;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input bit is_grant);
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL unexpected_%s: got event, required none (id=%0d)",
                  is_grant ? "grant" : "drop", bus.grant_id);
         return;
      end
      e = exp_q.pop_front();
      if (e.is_grant != is_grant) begin
         $display("FAIL event_kind: got %s required %s",
                  is_grant ? "grant" : "drop", e.is_grant ? "grant" : "drop");
      end else if (is_grant && (bus.grant_id !== e.id || bus.grant_onehot !== e.onehot)) begin
         $display("FAIL grant_event: got id=%0d onehot=%b required id=%0d onehot=%b",
                  bus.grant_id, bus.grant_onehot, e.id, e.onehot);
      end else begin
         n_pass++;
         if (is_grant) $display("t=%0t grant id=%0d onehot=%b", $time, bus.grant_id, bus.grant_onehot);
         else          $display("t=%0t dropped press", $time);
      end
   endtask

   // Monitor: grant rising edge and dropped pulses are scoreboard events.
   initial begin
      logic prev_valid;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.grant_valid === 1'b1 && prev_valid !== 1'b1) pop_check(1'b1);
         if (bus.dropped === 1'b1) pop_check(1'b0);
         check("onehot_consistent", {28'd0, bus.grant_onehot},
               bus.grant_valid ? {28'd0, 4'b0001 << bus.grant_id} : 32'd0);
         prev_valid = bus.grant_valid;
      end
   end

   task automatic do_ack();
      bus.grant_ack = 1'b1;
      cyc();
      bus.grant_ack = 1'b0;
      check("ack_release_valid", {31'd0, bus.grant_valid}, 32'd0);
      check("ack_busy", {31'd0, bus.busy}, {31'd0, LOCK_ON});
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && bus.busy === 1'b1; i++) cyc();
      check("wait_idle_busy", {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with presses asserted
      rst = 1'b1; bus.enable = 1'b1; bus.req = 4'b1111; bus.grant_ack = 1'b0;
      cyc(); cyc();
      check("rst_valid",  {31'd0, bus.grant_valid},  32'd0);
      check("rst_id",     {30'd0, bus.grant_id},     32'd0);
      check("rst_onehot", {28'd0, bus.grant_onehot}, 32'd0);
      check("rst_dropped",{31'd0, bus.dropped},      32'd0);
      check("rst_busy",   {31'd0, bus.busy},         32'd0);

      // Disabled: presses ignored, no drop
      rst = 1'b0; bus.enable = 1'b0; bus.req = 4'b1111;
      cyc();
      bus.req = 4'b0000;
      check("dis_valid",   {31'd0, bus.grant_valid}, 32'd0);
      check("dis_dropped", {31'd0, bus.dropped},     32'd0);
      bus.req = 4'b0101;
      cyc();
      bus.req = 4'b0000;
      check("dis_busy", {31'd0, bus.busy}, 32'd0);
      cyc();

      // Tie from rr_ptr=0: bit1 wins, bit3 dropped
      bus.enable = 1'b1; bus.req = 4'b1010;
      push_grant(2'd1); push_drop();
      cyc();
      bus.req = 4'b0000;
      check("tie1_id", {30'd0, bus.grant_id}, 32'd1);
      cyc();
      check("tie1_hold_valid", {31'd0, bus.grant_valid}, 32'd1);
      check("tie1_hold_id",    {30'd0, bus.grant_id},    32'd1);
      do_ack();
      wait_idle();

      // Same tie from rr_ptr=2: bit3 wins
      bus.req = 4'b1010;
      push_grant(2'd3); push_drop();
      cyc();
      bus.req = 4'b0000;
      check("tie2_id", {30'd0, bus.grant_id}, 32'd3);
      do_ack();
      wait_idle();

      // Single press, then a press during GRANT is dropped
      bus.req = 4'b0100;
      push_grant(2'd2);
      cyc();
      bus.req = 4'b1000;
      push_drop();
      check("single_id",     {30'd0, bus.grant_id},     32'd2);
      check("single_onehot", {28'd0, bus.grant_onehot}, 32'h4);
      cyc();
      bus.req = 4'b0000;
      check("grant_stable_id", {30'd0, bus.grant_id}, 32'd2);

      // Ack then press timing: lockout window or immediate re-grant
      bus.grant_ack = 1'b1;
      cyc();
      bus.grant_ack = 1'b0;
`ifdef BTN_ARB_LOCKOUT_EN
      check("lock_busy_t1", {31'd0, bus.busy}, 32'd1);
      cyc();
      bus.req = 4'b0001;
      push_drop();
      cyc();
      bus.req = 4'b0000;
      check("lock_no_grant", {31'd0, bus.grant_valid}, 32'd0);
      cyc();
      check("lock_busy_t4", {31'd0, bus.busy}, 32'd1);
      cyc();
      check("lock_done_busy", {31'd0, bus.busy}, 32'd0);
      bus.req = 4'b0001;
      push_grant(2'd0);
      cyc();
      bus.req = 4'b0000;
`else
      check("nolock_busy", {31'd0, bus.busy}, 32'd0);
      bus.req = 4'b0001;
      push_grant(2'd0);
      cyc();
      bus.req = 4'b0000;
`endif
      check("regrant_valid", {31'd0, bus.grant_valid}, 32'd1);
      check("regrant_id",    {30'd0, bus.grant_id},    32'd0);

      // Abort with simultaneous ack: rr_ptr must stay 3
      bus.enable = 1'b0; bus.grant_ack = 1'b1;
      cyc();
      bus.grant_ack = 1'b0; bus.enable = 1'b1;
      check("abort_valid",  {31'd0, bus.grant_valid},  32'd0);
      check("abort_busy",   {31'd0, bus.busy},         32'd0);
      check("abort_onehot", {28'd0, bus.grant_onehot}, 32'd0);
      bus.req = 4'b0011;
      push_grant(2'd0); push_drop();
      cyc();
      bus.req = 4'b0000;
      check("abort_rr_id", {30'd0, bus.grant_id}, 32'd0);
      do_ack();
`ifdef BTN_ARB_LOCKOUT_EN
      // Abort during LOCKOUT returns to IDLE at once
      bus.enable = 1'b0;
      cyc();
      bus.enable = 1'b1;
      check("lock_abort_busy", {31'd0, bus.busy}, 32'd0);
      bus.req = 4'b0010;
      push_grant(2'd1);
      cyc();
      bus.req = 4'b0000;
      check("lock_abort_grant", {31'd0, bus.grant_valid}, 32'd1);
      do_ack();
`endif
      wait_idle();

      // Reset mid-grant: outputs cleared, no drop, rr_ptr back to 0
      bus.req = 4'b0100;
      push_grant(2'd2);
      cyc();
      bus.req = 4'b1111; rst = 1'b1;
      cyc();
      check("mrst_valid",  {31'd0, bus.grant_valid},  32'd0);
      check("mrst_onehot", {28'd0, bus.grant_onehot}, 32'd0);
      check("mrst_busy",   {31'd0, bus.busy},         32'd0);
      rst = 1'b0; bus.req = 4'b0000;
      cyc();
      check("mrst_dropped", {31'd0, bus.dropped}, 32'd0);
      bus.req = 4'b1001;
      push_grant(2'd0); push_drop();
      cyc();
      bus.req = 4'b0000;
      check("mrst_rr_id", {30'd0, bus.grant_id}, 32'd0);
      do_ack();
      wait_idle();

      cyc(); cyc(); cyc();
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
